// File: rtl/write_back_pipe.sv
// Write-back stage: selects ALU / aligned load / link data, registers the
// register-file write, keeps a one-write-old bypass history and counts retired writes.
module write_back_pipe #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned REG_ADDR_WIDTH = 5,
   parameter int unsigned CNT_WIDTH      = 32
) (
   input  logic                      clk_87,
   input  logic                      rst_n_87,
   input  logic                      stall_87,
   input  logic                      flush_87,
   input  logic                      valid_in_87,
   input  logic                      reg_write_in_87,
   input  logic [1:0]                wb_sel_in_87,
   input  logic [1:0]                ld_size_in_87,
   input  logic                      ld_signed_in_87,
   input  logic [DATA_WIDTH-1:0]     alu_data_in_87,
   input  logic [DATA_WIDTH-1:0]     mem_data_in_87,
   input  logic [ADDR_WIDTH-1:0]     mem_addr_in_87,
   input  logic [ADDR_WIDTH-1:0]     pc_in_87,
   input  logic [REG_ADDR_WIDTH-1:0] wb_reg_in_87,
   output logic                      reg_write_out_87,
   output logic [DATA_WIDTH-1:0]     wb_data_87,
   output logic [REG_ADDR_WIDTH-1:0] wb_reg_out_87,
   output logic                      fwd_valid_87,
   output logic [REG_ADDR_WIDTH-1:0] fwd_reg_87,
   output logic [DATA_WIDTH-1:0]     fwd_data_87,
   output logic [CNT_WIDTH-1:0]      retired_cnt_87
);

   localparam int unsigned OFF_W = $clog2(DATA_WIDTH / 8);
   localparam int unsigned MSB_W = $clog2(DATA_WIDTH);

   logic [OFF_W-1:0]          off_c;
   logic [OFF_W-1:0]          lane_off_c;
   logic [DATA_WIDTH-1:0]     fmask_c;
   logic [MSB_W-1:0]          msb_c;
   logic [DATA_WIDTH-1:0]     shifted_c;
   logic [DATA_WIDTH-1:0]     field_c;
   logic                      sbit_c;
   logic [DATA_WIDTH-1:0]     ld_val_c;
   logic [ADDR_WIDTH-1:0]     link_addr_c;
   logic [DATA_WIDTH-1:0]     link_c;
   logic [DATA_WIDTH-1:0]     sel_val_c;
   logic                      cap_c;

   logic                      reg_write_d, reg_write_q;
   logic [DATA_WIDTH-1:0]     wb_data_d, wb_data_q;
   logic [REG_ADDR_WIDTH-1:0] wb_reg_d, wb_reg_q;
   logic                      fwd_valid_d, fwd_valid_q;
   logic [REG_ADDR_WIDTH-1:0] fwd_reg_d, fwd_reg_q;
   logic [DATA_WIDTH-1:0]     fwd_data_d, fwd_data_q;
   logic [CNT_WIDTH-1:0]      retired_cnt_d, retired_cnt_q;

   // Upper address bits only matter to the memory stage, not to lane selection.
   logic unused_addr_c;
   assign unused_addr_c = ^mem_addr_in_87[ADDR_WIDTH-1:OFF_W];

   // Little-endian lane selection; misaligned low offset bits are truncated.
   always_comb begin
      off_c      = mem_addr_in_87[OFF_W-1:0];
      lane_off_c = '0;
      fmask_c    = '1;
      msb_c      = MSB_W'(DATA_WIDTH - 1);
      case (ld_size_in_87)
         2'd0: begin
            lane_off_c = off_c;
            fmask_c    = DATA_WIDTH'(8'hFF);
            msb_c      = MSB_W'(7);
         end
         2'd1: begin
            lane_off_c = off_c & ~OFF_W'(1);
            fmask_c    = DATA_WIDTH'(16'hFFFF);
            msb_c      = MSB_W'(15);
         end
         2'd2: begin
            lane_off_c = off_c & ~OFF_W'(3);
            fmask_c    = DATA_WIDTH'(32'hFFFF_FFFF);
            msb_c      = MSB_W'(31);
         end
         default: begin
            lane_off_c = '0;
            fmask_c    = '1;
            msb_c      = MSB_W'(DATA_WIDTH - 1);
         end
      endcase
      shifted_c = mem_data_in_87 >> {lane_off_c, 3'b000};
      field_c   = shifted_c & fmask_c;
      sbit_c    = ld_signed_in_87 & field_c[msb_c];
      ld_val_c  = sbit_c ? (field_c | ~fmask_c) : field_c;
   end

   // Source select: link address wraps in address width before zero-extension.
   always_comb begin
      link_addr_c = pc_in_87 + ADDR_WIDTH'(8);
      link_c      = DATA_WIDTH'(link_addr_c);
      case (wb_sel_in_87)
         2'd1:    sel_val_c = ld_val_c;
         2'd2:    sel_val_c = link_c;
         default: sel_val_c = alu_data_in_87;
      endcase
      cap_c = valid_in_87 & reg_write_in_87 & ~stall_87 & ~flush_87 &
              (wb_reg_in_87 != '0);
   end

   // Next-state: stage capture, bypass history and retire counter.
   always_comb begin
      reg_write_d   = cap_c;
      wb_data_d     = wb_data_q;
      wb_reg_d      = wb_reg_q;
      fwd_valid_d   = reg_write_q;
      fwd_reg_d     = fwd_reg_q;
      fwd_data_d    = fwd_data_q;
      retired_cnt_d = retired_cnt_q;
      if (cap_c) begin
         wb_data_d = sel_val_c;
         wb_reg_d  = wb_reg_in_87;
      end
      if (reg_write_q) begin
         fwd_reg_d     = wb_reg_q;
         fwd_data_d    = wb_data_q;
         retired_cnt_d = retired_cnt_q + CNT_WIDTH'(1);
      end
   end

   // Stage and history registers, cleared asynchronously.
   always_ff @(posedge clk_87 or negedge rst_n_87) begin
      if (!rst_n_87) begin
         reg_write_q   <= 1'b0;
         wb_data_q     <= '0;
         wb_reg_q      <= '0;
         fwd_valid_q   <= 1'b0;
         fwd_reg_q     <= '0;
         fwd_data_q    <= '0;
         retired_cnt_q <= '0;
      end else begin
         reg_write_q   <= reg_write_d;
         wb_data_q     <= wb_data_d;
         wb_reg_q      <= wb_reg_d;
         fwd_valid_q   <= fwd_valid_d;
         fwd_reg_q     <= fwd_reg_d;
         fwd_data_q    <= fwd_data_d;
         retired_cnt_q <= retired_cnt_d;
      end
   end

   assign reg_write_out_87 = reg_write_q;
   assign wb_data_87       = wb_data_q;
   assign wb_reg_out_87    = wb_reg_q;
   assign fwd_valid_87     = fwd_valid_q;
   assign fwd_reg_87       = fwd_reg_q;
   assign fwd_data_87      = fwd_data_q;
   assign retired_cnt_87   = retired_cnt_q;

endmodule

// File: tb/tb_write_back_pipe.sv
// Scoreboard bench for write_back_pipe (32-bit data, 4-bit retire counter).
module tb_write_back_pipe;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 32;
   localparam int unsigned RW = 5;
   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          stall, flush, valid, rwr, sgn;
   logic [1:0]    sel, size;
   logic [DW-1:0] alu, mem;
   logic [AW-1:0] addr, pc;
   logic [RW-1:0] wreg;
   logic          rw_out, fwd_valid;
   logic [DW-1:0] wb_data, fwd_data;
   logic [RW-1:0] wb_reg, fwd_reg;
   logic [CW-1:0] cnt;

   always #5 clk = ~clk;

   write_back_pipe #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW)
   ) dut (
      .clk_87(clk), .rst_n_87(rst_n), .stall_87(stall), .flush_87(flush),
      .valid_in_87(valid), .reg_write_in_87(rwr), .wb_sel_in_87(sel),
      .ld_size_in_87(size), .ld_signed_in_87(sgn), .alu_data_in_87(alu),
      .mem_data_in_87(mem), .mem_addr_in_87(addr), .pc_in_87(pc),
      .wb_reg_in_87(wreg), .reg_write_out_87(rw_out), .wb_data_87(wb_data),
      .wb_reg_out_87(wb_reg), .fwd_valid_87(fwd_valid), .fwd_reg_87(fwd_reg),
      .fwd_data_87(fwd_data), .retired_cnt_87(cnt)
   );

   typedef struct {
      int unsigned   e;
      logic [RW-1:0] r;
      logic [DW-1:0] d;
   } wr_t;

   wr_t         sbq[$];
   int unsigned edge_n = 0;
   int          total = 0;
   int          bad = 0;

   // expected architectural state seen by the monitor
   logic          m_rw, m_fv;
   logic [RW-1:0] m_reg, m_freg;
   logic [DW-1:0] m_data, m_fdata;
   int            m_cnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Write value from the architectural rules, plain arithmetic.
   function automatic logic [DW-1:0] ref_val(input logic [1:0] s, input logic [1:0] sz,
                                             input logic sg, input logic [DW-1:0] a,
                                             input logic [DW-1:0] m, input logic [AW-1:0] ad,
                                             input logic [AW-1:0] p);
      longint unsigned v;
      int off, bits;
      if (s == 2'd1) begin
         off = int'(ad % 4);
         if (sz == 2'd0) begin
            bits = 8;  v = (64'(m) >> (8 * off)) % 256;
         end else if (sz == 2'd1) begin
            bits = 16; v = (64'(m) >> (16 * (off / 2))) % 65536;
         end else begin
            bits = 32; v = 64'(m);
         end
         if (sg && bits < 32 && v >= (64'(1) << (bits - 1))) v = v - (64'(1) << bits);
         return DW'(v);
      end else if (s == 2'd2) begin
         return DW'((64'(p) + 8) % 64'h1_0000_0000);
      end
      return a;
   endfunction

   // Record what each edge must write, from the inputs present at that edge.
   always @(posedge clk) begin
      edge_n++;
      if (rst_n && valid && rwr && !stall && !flush && wreg != 0)
         sbq.push_back('{edge_n, wreg, ref_val(sel, size, sgn, alu, mem, addr, pc)});
   end

   // Monitor: advance the expected state one edge and compare every output.
   always @(negedge clk) begin
      if (!rst_n) begin
         sbq.delete();
         m_rw = 0; m_fv = 0; m_reg = '0; m_freg = '0; m_data = '0; m_fdata = '0; m_cnt = 0;
         chk("rst_rw", 64'(rw_out), 64'(0));
         chk("rst_cnt", 64'(cnt), 64'(0));
      end else begin
         if (m_rw) begin
            m_freg  = m_reg;
            m_fdata = m_data;
            m_cnt   = (m_cnt + 1) % 16;
         end
         m_fv = m_rw;
         m_rw = (sbq.size() > 0) && (sbq[0].e == edge_n);
         if (m_rw) begin
            wr_t it;
            it = sbq.pop_front();
            m_reg  = it.r;
            m_data = it.d;
         end
         chk("mon_rw", 64'(rw_out), 64'(m_rw));
         chk("mon_wb_data", 64'(wb_data), 64'(m_data));
         chk("mon_wb_reg", 64'(wb_reg), 64'(m_reg));
         chk("mon_fwd_valid", 64'(fwd_valid), 64'(m_fv));
         chk("mon_fwd_reg", 64'(fwd_reg), 64'(m_freg));
         chk("mon_fwd_data", 64'(fwd_data), 64'(m_fdata));
         chk("mon_cnt", 64'(cnt), 64'(m_cnt));
      end
   end

   task automatic idle();
      valid = 0; rwr = 0; stall = 0; flush = 0; sel = '0; size = '0; sgn = 0;
      alu = '0; mem = '0; addr = '0; pc = '0; wreg = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put_alu(input logic [RW-1:0] r, input logic [DW-1:0] d);
      idle();
      valid = 1; rwr = 1; sel = 2'd0; alu = d; wreg = r;
   endtask

   task automatic do_reset();
      idle();
      #1 rst_n = 0;
      @(negedge clk);
      #1 rst_n = 1;
      step();
   endtask

   task automatic dload(input string nm, input logic [1:0] sz, input logic sg,
                        input logic [AW-1:0] ad, input logic [DW-1:0] exp);
      idle();
      valid = 1; rwr = 1; sel = 2'd1; size = sz; sgn = sg;
      mem = 32'h80FF_7F01; addr = ad; wreg = 5'd1;
      step();
      chk(nm, 64'(wb_data), 64'(exp));
   endtask

   task automatic dsel(input string nm, input logic [1:0] s, input logic [AW-1:0] p,
                       input logic [DW-1:0] exp);
      idle();
      valid = 1; rwr = 1; sel = s; alu = 32'h1234_5678; pc = p; wreg = 5'd2;
      mem = 32'hDEAD_BEEF;
      step();
      chk(nm, 64'(wb_data), 64'(exp));
   endtask

   initial begin
      rst_n = 0;
      idle();
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1 rst_n = 1;
      step();

      // load alignment and extension
      dload("ld_b_off1_s", 2'd0, 1'b1, 32'h0000_1001, 32'h0000_007F);
      dload("ld_b_off2_s", 2'd0, 1'b1, 32'h0000_1002, 32'hFFFF_FFFF);
      dload("ld_h_off2_s", 2'd1, 1'b1, 32'h0000_1002, 32'hFFFF_80FF);
      dload("ld_h_off3_u", 2'd1, 1'b0, 32'h0000_1003, 32'h0000_80FF);
      dload("ld_w_off3_s", 2'd2, 1'b1, 32'h0000_1003, 32'h80FF_7F01);

      // source select
      dsel("sel0", 2'd0, 32'h0040_0010, 32'h1234_5678);
      dsel("sel2", 2'd2, 32'h0040_0010, 32'h0040_0018);
      dsel("sel2_wrap", 2'd2, 32'hFFFF_FFFC, 32'h0000_0004);
      dsel("sel3", 2'd3, 32'h0040_0010, 32'h1234_5678);

      // stall / flush / r0
      do_reset();
      put_alu(5'd3, 32'h33);
      step();
      chk("st_e1_rw", 64'(rw_out), 64'(1));
      chk("st_e1_reg", 64'(wb_reg), 64'(3));
      put_alu(5'd4, 32'h44);
      stall = 1;
      step();
      chk("st_e2_bubble", 64'(rw_out), 64'(0));
      stall = 0;
      step();
      chk("st_e3_rw", 64'(rw_out), 64'(1));
      chk("st_e3_reg", 64'(wb_reg), 64'(4));
      chk("st_e3_data", 64'(wb_data), 64'(32'h44));
      put_alu(5'd5, 32'h55);
      flush = 1;
      step();
      chk("fl_rw", 64'(rw_out), 64'(0));
      chk("st_cnt", 64'(cnt), 64'(2));
      put_alu(5'd0, 32'h66);
      step();
      chk("r0_rw", 64'(rw_out), 64'(0));
      idle();
      step();
      chk("r0_cnt", 64'(cnt), 64'(2));

      // forwarding history
      put_alu(5'd7, 32'hA5);
      step();
      chk("fw_rw", 64'(rw_out), 64'(1));
      idle();
      step();
      chk("fw_rw_fall", 64'(rw_out), 64'(0));
      chk("fw_v1", 64'(fwd_valid), 64'(1));
      chk("fw_reg1", 64'(fwd_reg), 64'(7));
      chk("fw_data1", 64'(fwd_data), 64'(32'hA5));
      step();
      chk("fw_v0", 64'(fwd_valid), 64'(0));
      chk("fw_reg_hold", 64'(fwd_reg), 64'(7));
      chk("fw_data_hold", 64'(fwd_data), 64'(32'hA5));

      // asynchronous reset while a write is on the output
      put_alu(5'd9, 32'h99);
      step();
      chk("ar_pre_rw", 64'(rw_out), 64'(1));
      idle();
      #1 rst_n = 0;
      #1;
      chk("ar_rw", 64'(rw_out), 64'(0));
      chk("ar_data", 64'(wb_data), 64'(0));
      chk("ar_reg", 64'(wb_reg), 64'(0));
      chk("ar_fv", 64'(fwd_valid), 64'(0));
      chk("ar_freg", 64'(fwd_reg), 64'(0));
      chk("ar_fdata", 64'(fwd_data), 64'(0));
      chk("ar_cnt", 64'(cnt), 64'(0));
      @(negedge clk);
      #1 rst_n = 1;
      step();

      // counter wrap at 4 bits
      do_reset();
      for (int i = 0; i < 17; i++) begin
         put_alu(RW'(1 + (i % 31)), $urandom);
         step();
      end
      idle();
      step();
      chk("cnt_wrap", 64'(cnt), 64'(1));

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         valid = ($urandom % 8) != 0;
         rwr   = ($urandom % 5) != 0;
         sel   = 2'($urandom);
         size  = 2'($urandom);
         sgn   = 1'($urandom);
         alu   = $urandom;
         mem   = $urandom;
         addr  = $urandom;
         pc    = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | 32'($urandom % 16)) : $urandom;
         wreg  = RW'($urandom);
         stall = ($urandom % 6) == 0;
         flush = ($urandom % 8) == 0;
         step();
      end
      idle();
      repeat (3) step();
      chk("sb_drained", 64'(sbq.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
